test_status_scheduler: RTL and testbench



---
 rtl/test_status_scheduler_pkg.sv | 18 +
 rtl/test_status_scheduler_rr_pick.sv | 34 +++
 rtl/test_status_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_test_status_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/test_status_scheduler_pkg.sv
// Shared types and constants for the test-firmware status path (package test_pkg).
package test_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Blank character shown in a status cell before its first write
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    // Default widths for the character buffer address and a status code
    localparam int DEF_AW = 11;
    localparam int CODE_W = 8;

endpackage

// File: rtl/test_status_scheduler_rr_pick.sv
// rr_pick: combinational round-robin finder. Returns the first set pend bit
// found scanning rr_ptr+1, rr_ptr+2, ... with explicit wrap at N, so N need
// not be a power of two.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  pend,
    input  logic [IW-1:0] rr_ptr,
    output logic          any,
    output logic [IW-1:0] gnt_idx
);

    // Scan from farthest to nearest so the nearest candidate is assigned last and wins
    always_comb begin
        int idx;
        // NOTE: every output gets a default before the loop; a path that leaves
        // any or gnt_idx unassigned would infer a latch.
        any     = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = N; k >= 1; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (pend[idx]) begin
                any     = 1'b1;
                gnt_idx = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/test_status_scheduler.sv
// test_status_scheduler: shares one character-buffer write port between
// N_SRC status monitors. Changed (or never-written) codes are granted
// round-robin and written to each source's fixed text cell.
// Optional macro STATUS_FORCE_REFRESH_EN: every vs falling edge re-arms all
// cells so overwritten status text is repainted once per frame.
module test_status_scheduler
    import test_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int AW        = DEF_AW,
    parameter int BASE_ADDR = 'h050,
    parameter int STRIDE    = 40,
    parameter int VS_GATE   = 1,
    parameter int ACK_TO    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vs,
    input  logic [8*N_SRC-1:0]    src_code,
    input  logic [N_SRC-1:0]      src_valid,
    output logic                  wr_req,
    output logic [AW-1:0]         wr_addr,
    output logic [CODE_W-1:0]     wr_data,
    input  logic                  wr_ack,
    output logic                  busy,
    output logic [7:0]            drop_cnt
);

    localparam int         IW       = $clog2(N_SRC);
    localparam logic [7:0] ACK_TO_V = 8'(ACK_TO);

    state_t              state, state_nxt;
    logic                vs_meta, vs_sync;
    logic [CODE_W-1:0]   code   [N_SRC];
    logic [CODE_W-1:0]   shadow [N_SRC];
    logic [N_SRC-1:0]    init_pend;
    logic [N_SRC-1:0]    pend;
    logic [IW-1:0]       rr_ptr;
    logic [IW-1:0]       gnt_idx;
    logic                any;
    logic [7:0]          timer;
    logic                grant, done_ok, timeout;

    // Two-flop synchroniser for the asynchronous vertical sync
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value; blocking here would collapse the two
        // synchroniser stages into one.
        if (!rst_n) begin
            vs_meta <= 1'b1;
            vs_sync <= 1'b1;
        end else begin
            vs_meta <= vs;
            vs_sync <= vs_meta;
        end
    end

`ifdef STATUS_FORCE_REFRESH_EN
    logic vs_prev;
    logic vs_fall;

    // Delayed copy of vs_sync for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev <= 1'b1;
        end else begin
            vs_prev <= vs_sync;
        end
    end

    assign vs_fall = vs_prev & ~vs_sync;
`endif

    // Unpack the flat code bus and flag sources whose cell is stale
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            code[i] = src_code[8*i +: 8];
            pend[i] = src_valid[i] & ((code[i] != shadow[i]) | init_pend[i]);
        end
    end

    rr_pick #(.N(N_SRC), .IW(IW)) u_rr_pick (
        .pend    (pend),
        .rr_ptr  (rr_ptr),
        .any     (any),
        .gnt_idx (gnt_idx)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and per-cycle control strobes
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        done_ok   = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (any && ((VS_GATE == 0) || !vs_sync)) begin
                    grant     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (wr_ack) begin
                    done_ok   = 1'b1;
                    state_nxt = GAP;
                end else if (timer == ACK_TO_V) begin
                    timeout   = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request is a pure state decode, so reset removes it asynchronously
    assign wr_req = (state == ISSUE);
    assign busy   = (state == ISSUE) || (state == GAP);

    // Latch the granted write and run the acknowledge timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr <= '0;
            wr_data <= CHAR_SPACE;
            rr_ptr  <= IW'(N_SRC - 1);
            timer   <= '0;
        end else if (grant) begin
            wr_addr <= AW'(BASE_ADDR + int'(gnt_idx) * STRIDE);
            wr_data <= code[gnt_idx];
            rr_ptr  <= gnt_idx;
            timer   <= '0;
        end else if (state == ISSUE && !done_ok && !timeout) begin
            timer   <= timer + 8'd1;
        end
    end

    // Record the character actually written; rr_ptr still names the granted source
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: shadow is a handful of flops, not a RAM, and must start as
        // blanks so pend compares against what the screen really holds.
        if (!rst_n) begin
            for (int i = 0; i < N_SRC; i++) begin
                shadow[i] <= CHAR_SPACE;
            end
        end else if (done_ok) begin
            shadow[rr_ptr] <= wr_data;
        end
    end

    // First-write flags: cleared on ack, re-armed by reset (and by a vs fall when enabled)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_pend <= '1;
        end else begin
            if (done_ok) begin
                init_pend[rr_ptr] <= 1'b0;
            end
`ifdef STATUS_FORCE_REFRESH_EN
            if (vs_fall) begin
                init_pend <= '1;
            end
`endif
        end
    end

    // Saturating count of writes abandoned on timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (timeout && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_test_status_scheduler.sv
// Directed bench for test_status_scheduler (N_SRC=4, VS_GATE=1, ACK_TO=10).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_test_status_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vs;
    logic [31:0] src_code;
    logic [3:0]  src_valid;
    logic        wr_req;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic        busy;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [10:0] log_addr [16];

    typedef struct {
        logic [7:0]  code;
        logic [10:0] exp_addr;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs [4];

    always #5 clk = ~clk;

    test_status_scheduler #(
        .N_SRC     (4),
        .AW        (11),
        .BASE_ADDR ('h050),
        .STRIDE    (40),
        .VS_GATE   (1),
        .ACK_TO    (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vs        (vs),
        .src_code  (src_code),
        .src_valid (src_valid),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait up to budget falling edges for wr_req; any pending ack is one cycle wide
    task automatic wait_req(input int budget, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            wr_ack = 1'b0;
            if (wr_req) begin
                n  = k;
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Acknowledge every request immediately until idle_lim quiet cycles pass
    task automatic drain(input int idle_lim, output int n);
        int idle;
        n    = 0;
        idle = 0;
        for (int k = 0; k < 600 && idle < idle_lim; k++) begin
            @(negedge clk);
            wr_ack = 1'b0;
            if (wr_req) begin
                if (n < 16) log_addr[n] = wr_addr;
                n++;
                idle   = 0;
                wr_ack = 1'b1;
            end else begin
                idle++;
            end
        end
        wr_ack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  ok;
        int  hi;
        bit  seen;

        vecs[0] = '{code: 8'h2D, exp_addr: 11'h050, exp_data: 8'h2D};
        vecs[1] = '{code: 8'h60, exp_addr: 11'h078, exp_data: 8'h60};
        vecs[2] = '{code: 8'h7C, exp_addr: 11'h0A0, exp_data: 8'h7C};
        vecs[3] = '{code: 8'h2F, exp_addr: 11'h0C8, exp_data: 8'h2F};

        // ---- reset values ----
        rst_n     = 1'b0;
        vs        = 1'b0;
        wr_ack    = 1'b0;
        src_valid = 4'hF;
        for (int i = 0; i < 4; i++) src_code[8*i +: 8] = vecs[i].code;
        repeat (3) @(negedge clk);
        check("rst_wr_req",   32'(wr_req),   32'h0);
        check("rst_wr_addr",  32'(wr_addr),  32'h0);
        check("rst_wr_data",  32'(wr_data),  32'h20);
        check("rst_busy",     32'(busy),     32'h0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        rst_n = 1'b1;

        // ---- initial paint, immediate ack, 3-cycle spacing ----
        wait_req(10, n, ok);
        check("t1_first_req", 32'(ok), 32'h1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                wait_req(10, n, ok);
                check($sformatf("t1_spacing_%0d", i), 32'(n), 32'd3);
            end
            check($sformatf("t1_addr_%0d", i), 32'(wr_addr), 32'(vecs[i].exp_addr));
            check($sformatf("t1_data_%0d", i), 32'(wr_data), 32'(vecs[i].exp_data));
            check($sformatf("t1_busy_%0d", i), 32'(busy), 32'h1);
            wr_ack = 1'b1;
        end
        wait_req(20, n, ok);
        check("t1_idle_no_req", 32'(ok), 32'h0);
        check("t1_idle_busy",   32'(busy), 32'h0);

        // ---- code change during ISSUE, delayed ack ----
        src_code[15:8] = 8'h42;
        wait_req(5, n, ok);
        check("t2_latency", 32'(n), 32'd1);
        check("t2_s1_addr", 32'(wr_addr), 32'h078);
        src_code[23:16] = 8'h41;
        src_code[15:8]  = 8'h43;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (!wr_req || wr_data != 8'h42 || wr_addr != 11'h078) seen = 1'b1;
        end
        check("t2_s1_held_stable", 32'(seen), 32'h0);
        wr_ack = 1'b1;
        wait_req(10, n, ok);
        check("t2_s2_addr", 32'(wr_addr), 32'h0A0);
        check("t2_s2_data", 32'(wr_data), 32'h41);
        wr_ack = 1'b1;
        wait_req(10, n, ok);
        check("t2_s1_retry_addr", 32'(wr_addr), 32'h078);
        check("t2_s1_retry_data", 32'(wr_data), 32'h43);
        wr_ack = 1'b1;
        drain(10, n);
        check("t2_quiet", 32'(n), 32'd0);

        // ---- timeout, retry and drop counter saturation ----
        src_code[7:0] = 8'h5A;
        wait_req(5, n, ok);
        check("t3_req", 32'(ok), 32'h1);
        check("t3_addr", 32'(wr_addr), 32'h050);
        hi = 1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (wr_req) hi++;
            else break;
        end
        check("t3_req_high_cycles", 32'(hi), 32'd11);
        check("t3_drop_1", 32'(drop_cnt), 32'd1);
        wait_req(5, n, ok);
        check("t3_retry_gap", 32'(n), 32'd2);
        check("t3_retry_data", 32'(wr_data), 32'h5A);
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (drop_cnt == 8'hFF) break;
        end
        check("t3_drop_reach_255", 32'(drop_cnt), 32'd255);
        repeat (40) @(negedge clk);
        check("t3_drop_sat", 32'(drop_cnt), 32'd255);
        wait_req(20, n, ok);
        check("t3_still_retrying", 32'(ok), 32'h1);
        wr_ack = 1'b1;
        drain(10, n);
        check("t3_quiet_after_ack", 32'(n), 32'd0);
        check("t3_drop_kept", 32'(drop_cnt), 32'd255);

        // ---- vs gating: held off while vs=1, grant 3 cycles after vs falls ----
        vs = 1'b1;
        repeat (5) @(negedge clk);
        src_code[31:24] = 8'h51;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (wr_req) seen = 1'b1;
        end
        check("t4_gated_no_req", 32'(seen), 32'h0);
        vs = 1'b0;
        wait_req(10, n, ok);
        check("t4_ungate_latency", 32'(n), 32'd3);
        check("t4_addr", 32'(wr_addr), 32'h0C8);
        check("t4_data", 32'(wr_data), 32'h51);
        wr_ack = 1'b1;
        drain(10, n);

        // ---- reset mid-write, then full repaint ----
        src_code[15:8] = 8'h52;
        wait_req(10, n, ok);
        check("t5_req_before_rst", 32'(wr_req), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_wr_req", 32'(wr_req), 32'h0);
        check("t5_async_busy",   32'(busy),   32'h0);
        check("t5_async_drop",   32'(drop_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drain(10, n);
        check("t5_repaint_count", 32'(n), 32'd4);
        check("t5_repaint_first", 32'(log_addr[0]), 32'h050);
        check("t5_repaint_last",  32'(log_addr[3]), 32'h0C8);

        // ---- static codes across a vs falling edge ----
        vs = 1'b1;
        repeat (6) @(negedge clk);
        vs = 1'b0;
        drain(15, n);
`ifdef STATUS_FORCE_REFRESH_EN
        check("t6_frame_refresh", 32'(n), 32'd4);
`else
        check("t6_no_refresh", 32'(n), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
